result_accum_fifo: RTL and testbench

RESULT_ACCUM_FIFO -- requirements
Module: result_accum_fifo

---
 rtl/result_accum_fifo_pkg.sv | 17 +
 rtl/result_accum_fifo_sync_fifo.sv | 52 +++++
 rtl/result_accum_fifo.sv | 99 +++++++++
 tb/tb_result_accum_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/result_accum_fifo_pkg.sv
// Shared types and default sizing for the result accumulator and its output FIFO.
package result_accum_fifo_pkg;
  localparam int DEF_W     = 12;
  localparam int DEF_N     = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SW    = DEF_W + $clog2(DEF_N);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_SW-1:0]       sum;
    logic [$clog2(DEF_N):0]  cnt;
  } acc_word_t;
endpackage

// File: rtl/result_accum_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is refused unless a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Empty FIFO presents zero so the head reads clean right after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/result_accum_fifo.sv
// Folds groups of N samples (or a flushed partial group) into one word and queues it for the consumer.
//   state | meaning
//   IDLE  | no open group, acc=0, cnt=0
//   ACCUM | group open, 1 <= cnt <= N-1
module result_accum_fifo
  import result_accum_fifo_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [W-1:0]                  in_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W+$clog2(N)-1:0]        out_data,
  output logic [$clog2(N):0]            out_cnt,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow
);
  localparam int SW = W + $clog2(N);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] N_CNT = CW'(N);

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
  } word_t;

  state_t        state;
  logic [SW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum_next;
  logic [CW-1:0] cnt_next;
  logic          push_w;
  word_t         push_word;
  word_t         head;
  logic          fifo_full;
  logic          fifo_empty;

  always_comb begin
    sum_next  = acc + SW'(in_data);
    cnt_next  = cnt + CW'(1);
    push_w    = 1'b0;
    push_word = '0;
    if (in_valid) begin
      // A flush that arrives with the Nth sample still yields one full word.
      if (cnt_next == N_CNT || flush) begin
        push_w    = 1'b1;
        push_word = '{sum: sum_next, cnt: cnt_next};
      end
    end else if (flush && state == ACCUM) begin
      push_w    = 1'b1;
      push_word = '{sum: acc, cnt: cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_w && fifo_full && !(out_valid && out_ready)) overflow <= 1'b1;
      if (push_w) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else if (in_valid) begin
        state <= ACCUM;
        acc   <= sum_next;
        cnt   <= cnt_next;
      end
    end
  end

  sync_fifo #(
    .WIDTH (SW + CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_w),
    .din   (push_word),
    .pop   (out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.sum;
  assign out_cnt   = head.cnt;
endmodule

// File: tb/tb_result_accum_fifo.sv
// Directed bench for result_accum_fifo at default sizing (W=12, N=4, DEPTH=4).
module tb_result_accum_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_data;
  logic [2:0]  out_cnt;
  logic [2:0]  level;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  result_accum_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [11:0] d, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 12'd7; flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    rst = 1'b0; in_valid = 1'b0; in_data = '0;

    // 1,2,3,4 -> {10,4}
    send(12'd1, 1'b0); send(12'd2, 1'b0); send(12'd3, 1'b0);
    chk("grp_pending_level", level, 0);
    send(12'd4, 1'b0);
    chk("grp_out_valid", out_valid, 1);
    chk("grp_out_data", out_data, 10);
    chk("grp_out_cnt", out_cnt, 4);
    chk("grp_level", level, 1);
    tick();
    chk("grp_hold_data", out_data, 10);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("grp_pop_level", level, 0);

    // max samples, no wrap
    for (int i = 0; i < 4; i++) send(12'd4095, 1'b0);
    chk("max_out_data", out_data, 16380);
    chk("max_out_cnt", out_cnt, 4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 5,7 then flush -> {12,2}; second flush in IDLE does nothing
    send(12'd5, 1'b0); send(12'd7, 1'b0);
    do_flush();
    chk("flush_level", level, 1);
    chk("flush_out_data", out_data, 12);
    chk("flush_out_cnt", out_cnt, 2);
    do_flush();
    chk("idle_flush_level", level, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("idle_flush_drained", out_valid, 0);

    // flush with sample: 3 then (4+flush) -> {7,2}
    send(12'd3, 1'b0);
    send(12'd4, 1'b1);
    chk("flush_smp_level", level, 1);
    chk("flush_smp_data", out_data, 7);
    chk("flush_smp_cnt", out_cnt, 2);
    // flush on Nth sample -> exactly one {4,4}
    send(12'd1, 1'b0); send(12'd1, 1'b0); send(12'd1, 1'b0);
    send(12'd1, 1'b1);
    tick();
    chk("flush_nth_level", level, 2);
    out_ready = 1'b1; tick();
    chk("flush_nth_data", out_data, 4);
    chk("flush_nth_cnt", out_cnt, 4);
    tick(); out_ready = 1'b0;
    chk("flush_nth_empty", level, 0);

    // 5 words with no consumer: sums 4,8,12,16,20; last one dropped
    for (int w = 0; w < 5; w++) begin
      for (int s = 0; s < 4; s++) send(12'(w + 1), 1'b0);
      if (w == 3) chk("ovf_full_no_flag", overflow, 0);
    end
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_data", out_data, 4 * (i + 1));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_drain_empty", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // full FIFO, simultaneous push and pop
    do_reset();
    chk("rst2_overflow", overflow, 0);
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 4; s++) send(12'd2, 1'b0);
    chk("pp_full_level", level, 4);
    send(12'd1, 1'b0); send(12'd1, 1'b0); send(12'd1, 1'b0);
    out_ready = 1'b1;
    send(12'd1, 1'b0);
    out_ready = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_no_overflow", overflow, 0);
    chk("pp_head", out_data, 8);

    // reset mid-group with level 3
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("mid_level3", level, 3);
    send(12'd1, 1'b0); send(12'd1, 1'b0);
    in_valid = 1'b1; in_data = 12'd9;
    do_reset();
    in_valid = 1'b0; in_data = '0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    for (int i = 0; i < 3; i++) send(12'd1, 1'b0);
    chk("mid_fresh_pending", level, 0);
    send(12'd1, 1'b0);
    chk("mid_fresh_data", out_data, 4);
    chk("mid_fresh_cnt", out_cnt, 4);
    chk("mid_fresh_level", level, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
